// File: rtl/pulse_seq_pkg.sv
// ---------------------------------------------------------------------------
// pulse_seq_pkg
// Shared definitions for the pulse sequencer:
//   - phase codes and the phase_e state enum (IDLE..LOW, 3 bits)
//   - sat_t, a signed working type wide enough for DW+1-bit arithmetic
//     for any amplitude width up to 32 bits
//   - sat_add(): level + step, clamped at a limit in the direction of
//     travel and then clamped to the signed range of the amplitude code
// ---------------------------------------------------------------------------
package pulse_seq_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_DELAY = 3'd1;
    localparam logic [2:0] PH_RISE  = 3'd2;
    localparam logic [2:0] PH_HIGH  = 3'd3;
    localparam logic [2:0] PH_FALL  = 3'd4;
    localparam logic [2:0] PH_LOW   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = PH_IDLE,
        ST_DELAY = PH_DELAY,
        ST_RISE  = PH_RISE,
        ST_HIGH  = PH_HIGH,
        ST_FALL  = PH_FALL,
        ST_LOW   = PH_LOW
    } phase_e;

    // Working width: one guard bit above the widest supported amplitude code.
    localparam int SAT_W = 33;
    typedef logic signed [SAT_W-1:0] sat_t;

    // level + step, clamped at limit in the direction of travel (dir_up=1
    // means the ramp moves upwards towards limit), then clamped to the
    // signed range of a dw-bit code so a wrong-signed step cannot wrap.
    function automatic sat_t sat_add(
        input sat_t        level,
        input sat_t        step,
        input sat_t        limit,
        input logic        dir_up,
        input int unsigned dw
    );
        sat_t one_v;
        sat_t sum_v;
        sat_t max_v;
        sat_t min_v;
        sat_t res_v;
        one_v = 33'sd1;
        sum_v = level + step;
        max_v = (one_v <<< (dw - 32'd1)) - one_v;
        min_v = ~max_v;
        if (dir_up) begin
            res_v = (sum_v > limit) ? limit : sum_v;
        end else begin
            res_v = (sum_v < limit) ? limit : sum_v;
        end
        if (res_v > max_v) begin
            res_v = max_v;
        end else if (res_v < min_v) begin
            res_v = min_v;
        end else begin
            res_v = res_v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/pulse_seq_ramp.sv
// ---------------------------------------------------------------------------
// pulse_seq_ramp
// Holds the amplitude register and its per-phase update rule. The FSM
// supplies the current and next phase; the level for the next cycle is
// chosen from the phase being entered or continued.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (level -> 0)
//   phase_cur     phase of the current cycle
//   phase_nxt     phase of the next cycle
//   iv, pv        initial/low and pulse/high levels (effective config)
//   rstep, fstep  signed per-cycle increments for rise and fall
//   level         registered amplitude code
// ---------------------------------------------------------------------------
module pulse_seq_ramp
    import pulse_seq_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  phase_e        phase_cur,
    input  phase_e        phase_nxt,
    input  logic [DW-1:0] iv,
    input  logic [DW-1:0] pv,
    input  logic [DW-1:0] rstep,
    input  logic [DW-1:0] fstep,
    output logic [DW-1:0] level
);

    logic [DW-1:0] level_q;
    logic [DW-1:0] level_d;

    sat_t lvl_x_s;
    sat_t iv_x_s;
    sat_t pv_x_s;
    sat_t rstep_x_s;
    sat_t fstep_x_s;
    sat_t rise_base_s;
    sat_t fall_base_s;
    sat_t rise_v_s;
    sat_t fall_v_s;
    logic rise_up_s;
    logic fall_up_s;

    assign lvl_x_s   = {{(SAT_W-DW){level_q[DW-1]}}, level_q};
    assign iv_x_s    = {{(SAT_W-DW){iv[DW-1]}}, iv};
    assign pv_x_s    = {{(SAT_W-DW){pv[DW-1]}}, pv};
    assign rstep_x_s = {{(SAT_W-DW){rstep[DW-1]}}, rstep};
    assign fstep_x_s = {{(SAT_W-DW){fstep[DW-1]}}, fstep};

    // Rise travels iv -> pv, fall travels pv -> iv.
    assign rise_up_s = (pv_x_s >= iv_x_s);
    assign fall_up_s = (iv_x_s >= pv_x_s);

    // Saturating step candidates; a ramp entered fresh starts from its origin
    // level so a skipped neighbour phase cannot leave a stale starting point.
    always_comb begin
        rise_base_s = (phase_cur == ST_RISE) ? lvl_x_s : iv_x_s;
        fall_base_s = (phase_cur == ST_FALL) ? lvl_x_s : pv_x_s;
        rise_v_s    = sat_add(rise_base_s, rstep_x_s, pv_x_s, rise_up_s, DW);
        fall_v_s    = sat_add(fall_base_s, fstep_x_s, iv_x_s, fall_up_s, DW);
    end

    // Next level selected by the phase of the next cycle; HIGH forces pv,
    // which is also how the end of a rise snaps to the pulse level.
    always_comb begin
        level_d = level_q;
        case (phase_nxt)
            ST_RISE:  level_d = rise_v_s[DW-1:0];
            ST_HIGH:  level_d = pv;
            ST_FALL:  level_d = fall_v_s[DW-1:0];
            ST_IDLE:  level_d = iv;
            ST_DELAY: level_d = iv;
            ST_LOW:   level_d = iv;
            default:  level_d = iv;
        endcase
    end

    // Amplitude register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= {DW{1'b0}};
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/pulse_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_sequencer
// Timing controller for a rectangular/trapezoidal pulse source. After a
// start strobe it walks DELAY once, then repeats RISE, HIGH, FALL, LOW until
// stopped, driving an amplitude code through pulse_seq_ramp.
//
// Build option: define PULSE_SEQ_BURST_EN to add cfg_nburst/burst_done; a
// non-zero burst count returns the sequencer to IDLE after that many periods.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_valid/cfg_ready   configuration handshake (ready only in IDLE)
//   cfg_td..cfg_tl        delay/rise/high/fall/low durations in cycles
//   cfg_iv, cfg_pv        initial/low and pulse/high levels
//   cfg_rstep, cfg_fstep  signed per-cycle rise/fall increments
//   cfg_nburst            periods per burst, 0 = endless (burst build only)
//   start, stop           single-cycle strobes, stop wins
//   level                 amplitude code
//   phase                 current state code (IDLE=0 .. LOW=5)
//   busy                  not IDLE
//   period_done           high during the last LOW cycle of each period
//   burst_done            high with the final period_done (burst build only)
// ---------------------------------------------------------------------------
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CW = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_td,
    input  logic [CW-1:0] cfg_tr,
    input  logic [CW-1:0] cfg_th,
    input  logic [CW-1:0] cfg_tf,
    input  logic [CW-1:0] cfg_tl,
    input  logic [DW-1:0] cfg_iv,
    input  logic [DW-1:0] cfg_pv,
    input  logic [DW-1:0] cfg_rstep,
    input  logic [DW-1:0] cfg_fstep,
`ifdef PULSE_SEQ_BURST_EN
    input  logic [15:0]   cfg_nburst,
    output logic          burst_done,
`endif
    input  logic          start,
    input  logic          stop,
    output logic [DW-1:0] level,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          period_done
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Shadow configuration.
    logic [CW-1:0] td_q, tr_q, th_q, tf_q, tl_q;
    logic [CW-1:0] td_d, tr_d, th_d, tf_d, tl_d;
    logic [DW-1:0] iv_q, pv_q, rstep_q, fstep_q;
    logic [DW-1:0] iv_d, pv_d, rstep_d, fstep_d;

    // Sequencer state.
    phase_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          pdone_q, pdone_d;

    logic          xfer_s;
    logic          enter_s;
    phase_e        target_s;
    phase_e        res_state_s;
    logic [CW-1:0] res_cnt_s;
    logic          last_s;

`ifdef PULSE_SEQ_BURST_EN
    logic [15:0]   nburst_q, nburst_d;
    logic [15:0]   bcnt_q, bcnt_d;
    logic          bdone_q, bdone_d;

    // The period now ending is the last one of a finite burst.
    assign last_s = (nburst_d != 16'd0) &&
                    (({1'b0, bcnt_q} + 17'd1) == {1'b0, nburst_d});
`else
    assign last_s = 1'b0;
`endif

    assign xfer_s = cfg_valid && cfg_ready_q;

    // Shadow next values; the _d copies double as the effective config so a
    // start in the transfer cycle already sees the new settings.
    always_comb begin
        if (xfer_s) begin
            td_d    = cfg_td;
            tr_d    = cfg_tr;
            th_d    = cfg_th;
            tf_d    = cfg_tf;
            tl_d    = cfg_tl;
            iv_d    = cfg_iv;
            pv_d    = cfg_pv;
            rstep_d = cfg_rstep;
            fstep_d = cfg_fstep;
        end else begin
            td_d    = td_q;
            tr_d    = tr_q;
            th_d    = th_q;
            tf_d    = tf_q;
            tl_d    = tl_q;
            iv_d    = iv_q;
            pv_d    = pv_q;
            rstep_d = rstep_q;
            fstep_d = fstep_q;
        end
    end

`ifdef PULSE_SEQ_BURST_EN
    // Burst length shadow.
    always_comb begin
        if (xfer_s) begin
            nburst_d = cfg_nburst;
        end else begin
            nburst_d = nburst_q;
        end
    end
`endif

    // Shadow configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            td_q    <= CNT_ZERO;
            tr_q    <= CNT_ZERO;
            th_q    <= CNT_ZERO;
            tf_q    <= CNT_ZERO;
            tl_q    <= CNT_ZERO;
            iv_q    <= {DW{1'b0}};
            pv_q    <= {DW{1'b0}};
            rstep_q <= {DW{1'b0}};
            fstep_q <= {DW{1'b0}};
        end else begin
            td_q    <= td_d;
            tr_q    <= tr_d;
            th_q    <= th_d;
            tf_q    <= tf_d;
            tl_q    <= tl_d;
            iv_q    <= iv_d;
            pv_q    <= pv_d;
            rstep_q <= rstep_d;
            fstep_q <= fstep_d;
        end
    end

    // Next state and counter. A phase entered with a zero duration falls
    // through to the next one in the same cycle; LOW always lasts >= 1 cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_s     = 1'b0;
        target_s    = ST_IDLE;
        res_state_s = ST_LOW;
        res_cnt_s   = CNT_ONE;
`ifdef PULSE_SEQ_BURST_EN
        bcnt_d      = bcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    enter_s  = 1'b1;
                    target_s = ST_DELAY;
`ifdef PULSE_SEQ_BURST_EN
                    bcnt_d   = 16'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (cnt_q == CNT_ONE) begin
                    enter_s  = 1'b1;
                    target_s = ST_RISE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RISE: begin
                if (cnt_q == CNT_ONE) begin
                    enter_s  = 1'b1;
                    target_s = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (cnt_q == CNT_ONE) begin
                    enter_s  = 1'b1;
                    target_s = ST_FALL;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_FALL: begin
                if (cnt_q == CNT_ONE) begin
                    enter_s  = 1'b1;
                    target_s = ST_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (cnt_q == CNT_ONE) begin
`ifdef PULSE_SEQ_BURST_EN
                    bcnt_d = bcnt_q + 16'd1;
`endif
                    if (last_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        enter_s  = 1'b1;
                        target_s = ST_RISE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Zero-duration fall-through, in phase order.
        res_state_s = target_s;
        if ((res_state_s == ST_DELAY) && (td_d == CNT_ZERO)) begin
            res_state_s = ST_RISE;
        end else begin
            res_state_s = res_state_s;
        end
        if ((res_state_s == ST_RISE) && (tr_d == CNT_ZERO)) begin
            res_state_s = ST_HIGH;
        end else begin
            res_state_s = res_state_s;
        end
        if ((res_state_s == ST_HIGH) && (th_d == CNT_ZERO)) begin
            res_state_s = ST_FALL;
        end else begin
            res_state_s = res_state_s;
        end
        if ((res_state_s == ST_FALL) && (tf_d == CNT_ZERO)) begin
            res_state_s = ST_LOW;
        end else begin
            res_state_s = res_state_s;
        end
        case (res_state_s)
            ST_DELAY: res_cnt_s = td_d;
            ST_RISE:  res_cnt_s = tr_d;
            ST_HIGH:  res_cnt_s = th_d;
            ST_FALL:  res_cnt_s = tf_d;
            ST_LOW:   res_cnt_s = (tl_d == CNT_ZERO) ? CNT_ONE : tl_d;
            default:  res_cnt_s = CNT_ONE;
        endcase

        if (enter_s) begin
            state_d = res_state_s;
            cnt_d   = res_cnt_s;
        end else begin
            state_d = state_d;
        end

        // Abort overrides everything, including a coincident start.
        if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            state_d = state_d;
        end
    end

    // Registered status flags, derived from the next state.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        cfg_ready_d = (state_d == ST_IDLE);
        pdone_d     = (state_d == ST_LOW) && (cnt_d == CNT_ONE);
`ifdef PULSE_SEQ_BURST_EN
        bdone_d     = pdone_d && (nburst_d != 16'd0) &&
                      (({1'b0, bcnt_d} + 17'd1) == {1'b0, nburst_d});
`endif
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            pdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            pdone_q     <= pdone_d;
        end
    end

`ifdef PULSE_SEQ_BURST_EN
    // Burst length, period count and burst-complete flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nburst_q <= 16'd0;
            bcnt_q   <= 16'd0;
            bdone_q  <= 1'b0;
        end else begin
            nburst_q <= nburst_d;
            bcnt_q   <= bcnt_d;
            bdone_q  <= bdone_d;
        end
    end

    assign burst_done = bdone_q;
`endif

    pulse_seq_ramp #(
        .DW (DW)
    ) u_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_cur (state_q),
        .phase_nxt (state_d),
        .iv        (iv_d),
        .pv        (pv_d),
        .rstep     (rstep_d),
        .fstep     (fstep_d),
        .level     (level)
    );

    assign cfg_ready   = cfg_ready_q;
    assign phase       = state_q;
    assign busy        = busy_q;
    assign period_done = pdone_q;

endmodule
